neighbor_builder: RTL and testbench
===================================

NEIGHBOR_BUILDER -- requirements
Module: neighbor_builder

Interface
REQ-001 Parameter MAX_NEIGHBOR_COUNT, default 10: words per NBR RAM entry (1 count word + MAX_NEIGHBOR_COUNT-1 neighbor slots).
REQ-002 Parameter ADDR_WIDTH, default 9: RAM address width.
REQ-003 clk  input  1  single clock; all state updates on its falling edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  level; sampled only in IDLE.
REQ-006 vertex_count  input  32  number of vertices; held stable while busy.
REQ-007 face_count  input  32  number of triangular faces; held stable while busy.
REQ-008 RAM_OBJ_Do  input  32  OBJ RAM read data.
REQ-009 RAM_OBJ_EN  output  1  OBJ RAM enable; read-only port.
REQ-010 RAM_OBJ_A  output  ADDR_WIDTH  OBJ RAM word address.
REQ-011 RAM_NBR_Do  input  32  NBR RAM read data.
REQ-012 RAM_NBR_EN  output  1  NBR RAM enable.
REQ-013 RAM_NBR_A  output  ADDR_WIDTH  NBR RAM word address.
REQ-014 RAM_NBR_WE  output  4  NBR RAM byte write enables; 4'b1111 or 4'b0000 only.
REQ-015 RAM_NBR_Di  output  32  NBR RAM write data.
REQ-016 busy  output  1  high from the edge accepting start until the return to IDLE.
REQ-017 overflow  output  1  sticky; a neighbor was dropped because its entry was full.
REQ-018 bad_index  output  1  sticky; a face index was 0 or greater than vertex_count.

Function
REQ-019 OBJ layout: vertices at words 0..3*vertex_count-1; face f at words 3*vertex_count+3f..+2, holding 1-based vertex indices a, b, c.
REQ-020 NBR layout: entry for 1-based vertex v at base (v-1)*MAX_NEIGHBOR_COUNT; word 0 = count; words 1..count = 1-based neighbor indices in insertion order.
REQ-021 RAM read latency: data for an address driven at edge N is valid on RAM_*_Do at edge N+1.
REQ-022 States: IDLE, CLEAR, FACE_RD, PAIR, CNT_RD, SCAN, APPEND, CNT_WR.
REQ-023 IDLE: busy=0, EN=0, WE=0; when start=1, clear overflow and bad_index, set busy=1, go to CLEAR.
REQ-024 CLEAR: write 0 to word 0 of every entry v=1..vertex_count, one per cycle; then FACE_RD (or IDLE if face_count=0).
REQ-025 FACE_RD: read a, b, c of the current face (3 address cycles plus 1 latency cycle), then PAIR.
REQ-026 PAIR: process ordered pairs (owner,nbr) in the order (a,b),(a,c),(b,a),(b,c),(c,a),(c,b); skip pairs with owner==nbr; skip pairs with either index out of range and set bad_index.
REQ-027 CNT_RD: read count of owner entry; SCAN: compare slots 1..count with nbr, one per cycle; on a match, abandon the pair and return to PAIR.
REQ-028 APPEND: if count < MAX_NEIGHBOR_COUNT-1, write nbr at slot count+1; else set overflow, write nothing, return to PAIR.
REQ-029 CNT_WR: write count+1 to word 0, return to PAIR.
REQ-030 After the 6th pair, advance the face; after face face_count-1, go to IDLE with busy=0 on the same edge.
REQ-031 WE is asserted only in CLEAR, APPEND and CNT_WR, and for exactly one cycle per write.
REQ-032 start while busy is ignored. Address arithmetic is computed in 32 bits and truncated to ADDR_WIDTH.

Reset
REQ-033 When rst=1 at a falling edge: state=IDLE, busy=0, overflow=0, bad_index=0, all EN/WE=0, all A/Di=0; this overrides any operation in progress.
REQ-034 An in-flight NBR write is dropped; NBR contents after a mid-operation reset are undefined until the next full run.

Verification
REQ-035 vertex_count=3, face (1,2,3) -> NBR[0..2]=2,2,3; NBR[10..12]=2,1,3; NBR[20..22]=2,1,2; overflow=0.
REQ-036 vertex_count=4, faces (1,2,3),(1,3,4) -> entry1={3:2,3,4}, entry3={3:1,2,4}, entry4={2:1,3}; duplicates not repeated.
REQ-037 Fan of 10 faces around vertex 1 (11 vertices) -> entry1 count=9, slots hold the first 9 distinct neighbors, overflow=1.
REQ-038 face (1,1,5) with vertex_count=4 -> bad_index=1; the self-pair is skipped; entries 1..4 count=0.
REQ-039 face_count=0 -> counts cleared, busy drops after vertex_count+1 cycles; rst asserted mid-SCAN -> next edge busy=0, WE=0; a following start completes correctly.

Source files
------------

// File: rtl/neighbor_builder.sv
// neighbor_builder: builds per-vertex neighbor lists in NBR RAM from triangle faces in OBJ RAM.
// Outputs are registered with the state, so RAM accesses line up with the state that issued them.
module neighbor_builder #(
   parameter int MAX_NEIGHBOR_COUNT = 10,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [31:0]           vertex_count,
   input  logic [31:0]           face_count,
   input  logic [31:0]           RAM_OBJ_Do,
   output logic                  RAM_OBJ_EN,
   output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
   input  logic [31:0]           RAM_NBR_Do,
   output logic                  RAM_NBR_EN,
   output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
   output logic [3:0]            RAM_NBR_WE,
   output logic [31:0]           RAM_NBR_Di,
   output logic                  busy,
   output logic                  overflow,
   output logic                  bad_index
);
   localparam logic [31:0] M = 32'(MAX_NEIGHBOR_COUNT);
   typedef enum logic [2:0] {IDLE, CLEAR, FACE_RD, PAIR, CNT_RD, SCAN, APPEND, CNT_WR} state_t;
   state_t state, state_n;
   logic [31:0] idx, idx_n, face, face_n, a, a_n, b, b_n, c, c_n;
   logic [31:0] owner, owner_n, nbr, nbr_n, cnt, cnt_n, slot, slot_n;
   logic [2:0] pair, pair_n;
   logic busy_n, ovf_n, bad_n, obj_en_n, nbr_en_n, we_n;
   logic [ADDR_WIDTH-1:0] obj_a_n, nbr_a_n;
   logic [31:0] di_n, fbase, p_own, p_nbr, nb, ac;
   logic p_bad, full;
   assign fbase = 32'd3 * vertex_count + 32'd3 * face;
   assign p_own = pair < 3'd2 ? a : pair < 3'd4 ? b : c;
   assign p_nbr = (pair == 3'd0 || pair == 3'd5) ? b : (pair == 3'd1 || pair == 3'd3) ? c : a;
   assign p_bad = p_own == 0 || p_own > vertex_count || p_nbr == 0 || p_nbr > vertex_count;
   assign nb = (owner - 32'd1) * M;
   // count seen by the append decision: fresh from RAM in CNT_RD, latched afterwards
   assign ac = state == CNT_RD ? RAM_NBR_Do : cnt;
   assign full = ac >= M - 32'd1;
   always_comb begin
      state_n = state;
      idx_n = idx;
      face_n = face;
      a_n = a;
      b_n = b;
      c_n = c;
      owner_n = owner;
      nbr_n = nbr;
      cnt_n = cnt;
      slot_n = slot;
      pair_n = pair;
      busy_n = busy;
      ovf_n = overflow;
      bad_n = bad_index;
      obj_en_n = 1'b0;
      obj_a_n = '0;
      nbr_en_n = 1'b0;
      nbr_a_n = '0;
      we_n = 1'b0;
      di_n = '0;
      case (state)
         IDLE: if (start) begin
            state_n = CLEAR;
            busy_n = 1'b1;
            ovf_n = 1'b0;
            bad_n = 1'b0;
            idx_n = '0;
         end
         CLEAR: if (idx < vertex_count) begin
            nbr_en_n = 1'b1;
            we_n = 1'b1;
            nbr_a_n = ADDR_WIDTH'(idx * M);
            idx_n = idx + 32'd1;
         end else if (face_count == 0) begin
            state_n = IDLE;
            busy_n = 1'b0;
         end else begin
            state_n = FACE_RD;
            face_n = '0;
            idx_n = '0;
         end
         FACE_RD: begin
            obj_en_n = idx < 32'd3;
            obj_a_n = idx < 32'd3 ? ADDR_WIDTH'(fbase + idx) : '0;
            a_n = idx == 32'd1 ? RAM_OBJ_Do : a;
            b_n = idx == 32'd2 ? RAM_OBJ_Do : b;
            c_n = idx == 32'd3 ? RAM_OBJ_Do : c;
            idx_n = idx + 32'd1;
            state_n = idx == 32'd3 ? PAIR : FACE_RD;
            pair_n = '0;
         end
         PAIR: if (pair == 3'd6) begin
            if (face == face_count - 32'd1) begin
               state_n = IDLE;
               busy_n = 1'b0;
            end else begin
               state_n = FACE_RD;
               face_n = face + 32'd1;
               idx_n = '0;
            end
         end else begin
            pair_n = pair + 3'd1;
            bad_n = bad_index | p_bad;
            if (!p_bad && p_own != p_nbr) begin
               owner_n = p_own;
               nbr_n = p_nbr;
               nbr_en_n = 1'b1;
               nbr_a_n = ADDR_WIDTH'((p_own - 32'd1) * M);
               state_n = CNT_RD;
            end
         end
         CNT_RD, SCAN: begin
            cnt_n = ac;
            if (state == SCAN && RAM_NBR_Do == nbr) state_n = PAIR;
            else if (ac == 0 || (state == SCAN && slot == cnt)) begin
               state_n = APPEND;
               nbr_en_n = !full;
               we_n = !full;
               nbr_a_n = ADDR_WIDTH'(nb + ac + 32'd1);
               di_n = nbr;
            end else begin
               state_n = SCAN;
               slot_n = state == CNT_RD ? 32'd1 : slot + 32'd1;
               nbr_en_n = 1'b1;
               nbr_a_n = ADDR_WIDTH'(nb + (state == CNT_RD ? 32'd1 : slot + 32'd1));
            end
         end
         APPEND: if (full) begin
            ovf_n = 1'b1;
            state_n = PAIR;
         end else begin
            state_n = CNT_WR;
            nbr_en_n = 1'b1;
            we_n = 1'b1;
            nbr_a_n = ADDR_WIDTH'(nb);
            di_n = cnt + 32'd1;
         end
         CNT_WR: state_n = PAIR;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(negedge clk) begin
      if (rst) begin
         state <= IDLE;
         {idx, face, a, b, c, owner, nbr, cnt, slot} <= '0;
         pair <= '0;
         {busy, overflow, bad_index, RAM_OBJ_EN, RAM_NBR_EN} <= '0;
         RAM_OBJ_A <= '0;
         RAM_NBR_A <= '0;
         RAM_NBR_WE <= '0;
         RAM_NBR_Di <= '0;
      end else begin
         state <= state_n;
         idx <= idx_n;
         face <= face_n;
         a <= a_n;
         b <= b_n;
         c <= c_n;
         owner <= owner_n;
         nbr <= nbr_n;
         cnt <= cnt_n;
         slot <= slot_n;
         pair <= pair_n;
         busy <= busy_n;
         overflow <= ovf_n;
         bad_index <= bad_n;
         RAM_OBJ_EN <= obj_en_n;
         RAM_OBJ_A <= obj_a_n;
         RAM_NBR_EN <= nbr_en_n;
         RAM_NBR_A <= nbr_a_n;
         RAM_NBR_WE <= {4{we_n}};
         RAM_NBR_Di <= di_n;
      end
   end
endmodule

// File: tb/tb_neighbor_builder.sv
// tb_neighbor_builder: directed checks of neighbor_builder against hand-computed NBR RAM contents.
module tb_neighbor_builder;
   logic clk = 1'b0;
   logic rst, start, RAM_OBJ_EN, RAM_NBR_EN, busy, overflow, bad_index;
   logic [31:0] vertex_count, face_count, RAM_OBJ_Do, RAM_NBR_Do, RAM_NBR_Di;
   logic [8:0] RAM_OBJ_A, RAM_NBR_A;
   logic [3:0] RAM_NBR_WE;
   logic [31:0] obj [0:511];
   logic [31:0] nbr [0:511];
   int passed = 0, total = 0, n;
   neighbor_builder dut (
      .clk(clk), .rst(rst), .start(start), .vertex_count(vertex_count), .face_count(face_count),
      .RAM_OBJ_Do(RAM_OBJ_Do), .RAM_OBJ_EN(RAM_OBJ_EN), .RAM_OBJ_A(RAM_OBJ_A),
      .RAM_NBR_Do(RAM_NBR_Do), .RAM_NBR_EN(RAM_NBR_EN), .RAM_NBR_A(RAM_NBR_A),
      .RAM_NBR_WE(RAM_NBR_WE), .RAM_NBR_Di(RAM_NBR_Di),
      .busy(busy), .overflow(overflow), .bad_index(bad_index)
   );
   always #5 clk = ~clk;
   assign RAM_OBJ_Do = obj[RAM_OBJ_A];
   assign RAM_NBR_Do = nbr[RAM_NBR_A];
   always @(negedge clk) if (RAM_NBR_EN && RAM_NBR_WE == 4'hF) nbr[RAM_NBR_A] <= RAM_NBR_Di;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
   endtask
   task automatic set_face(input int v, input int f, input int fa, input int fb, input int fc);
      obj[3*v+3*f] = fa;
      obj[3*v+3*f+1] = fb;
      obj[3*v+3*f+2] = fc;
   endtask
   task automatic ent(input string tag, input int v, input int c, input int s1, input int s2, input int s3);
      chk({tag, "_cnt"}, nbr[(v-1)*10], c);
      if (c > 0) chk({tag, "_s1"}, nbr[(v-1)*10+1], s1);
      if (c > 1) chk({tag, "_s2"}, nbr[(v-1)*10+2], s2);
      if (c > 2) chk({tag, "_s3"}, nbr[(v-1)*10+3], s3);
   endtask
   task automatic run(input int v, input int f);
      vertex_count = v;
      face_count = f;
      @(posedge clk) start = 1'b1;
      @(posedge clk) start = 1'b0;
      for (int i = 0; i < 5000 && busy; i++) @(posedge clk);
      chk("run_done", busy, 0);
   endtask
   initial begin
      rst = 1'b1;
      start = 1'b0;
      vertex_count = 0;
      face_count = 0;
      for (int i = 0; i < 512; i++) begin
         obj[i] = 32'hdead0000 + i;
         nbr[i] = 32'h77;
      end
      repeat (2) @(posedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_bad", bad_index, 0);
      chk("rst_en", {RAM_OBJ_EN, RAM_NBR_EN, RAM_NBR_WE}, 0);
      chk("rst_addr", {RAM_OBJ_A, RAM_NBR_A}, 0);
      chk("rst_di", RAM_NBR_Di, 0);
      rst = 1'b0;
      set_face(3, 0, 1, 2, 3);
      run(3, 1);
      ent("t1_e1", 1, 2, 2, 3, 0);
      ent("t1_e2", 2, 2, 1, 3, 0);
      ent("t1_e3", 3, 2, 1, 2, 0);
      chk("t1_ovf", overflow, 0);
      chk("t1_bad", bad_index, 0);
      set_face(4, 0, 1, 2, 3);
      set_face(4, 1, 1, 3, 4);
      run(4, 2);
      ent("t2_e1", 1, 3, 2, 3, 4);
      ent("t2_e2", 2, 2, 1, 3, 0);
      ent("t2_e3", 3, 3, 1, 2, 4);
      ent("t2_e4", 4, 2, 1, 3, 0);
      chk("t2_ovf", overflow, 0);
      for (int f = 0; f < 10; f++) set_face(11, f, 1, f + 2, f == 9 ? 2 : f + 3);
      run(11, 10);
      chk("fan_cnt", nbr[0], 9);
      for (int i = 1; i <= 9; i++) chk($sformatf("fan_s%0d", i), nbr[i], i + 1);
      ent("fan_e11", 11, 3, 1, 10, 2);
      chk("fan_ovf", overflow, 1);
      for (int v = 0; v < 4; v++) nbr[v*10] = 7;
      set_face(4, 0, 1, 1, 5);
      run(4, 1);
      chk("bad_flag", bad_index, 1);
      chk("bad_ovf_cleared", overflow, 0);
      for (int v = 1; v <= 4; v++) chk($sformatf("bad_e%0d_cnt", v), nbr[(v-1)*10], 0);
      for (int v = 0; v < 6; v++) nbr[v*10] = 7;
      vertex_count = 5;
      face_count = 0;
      @(posedge clk) start = 1'b1;
      @(posedge clk) start = 1'b0;
      n = 0;
      for (int i = 0; i < 100 && busy; i++) begin
         n++;
         @(posedge clk);
      end
      chk("f0_busy_cycles", n, 6);
      for (int v = 1; v <= 5; v++) chk($sformatf("f0_e%0d_cnt", v), nbr[(v-1)*10], 0);
      chk("f0_e6_untouched", nbr[50], 7);
      set_face(4, 0, 1, 2, 3);
      set_face(4, 1, 1, 3, 4);
      vertex_count = 4;
      face_count = 2;
      @(posedge clk) start = 1'b1;
      @(posedge clk) start = 1'b0;
      n = 0;
      for (int i = 0; i < 2000; i++) begin
         if (RAM_NBR_EN && RAM_NBR_WE == 4'h0 && RAM_NBR_A % 10 != 0) begin
            n = 1;
            break;
         end
         @(posedge clk);
      end
      chk("scan_seen", n, 1);
      rst = 1'b1;
      @(posedge clk);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_we", RAM_NBR_WE, 0);
      chk("mid_rst_en", RAM_NBR_EN, 0);
      rst = 1'b0;
      run(4, 2);
      ent("rerun_e1", 1, 3, 2, 3, 4);
      ent("rerun_e3", 3, 3, 1, 2, 4);
      ent("rerun_e4", 4, 2, 1, 3, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
